// File: rtl/dmem_port_arbiter_if.sv
// Purpose: bundles the two-requester request/response handshake and the memory-side port of the dmem arbiter.
// Latency: none; wires only.
// Backpressure: valid/yumi on every channel; the receiver's yumi completes a transfer.
interface dmem_port_arbiter_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  // requester side (bit 0 = core XM stage, bit 1 = net/debug loader)
  logic [1:0]                  rq_valid_i;
  logic [1:0]                  rq_wen_i;
  logic [1:0]                  rq_byte_i;
  logic [2*addr_width_p-1:0]   rq_addr_i;
  logic [2*data_width_p-1:0]   rq_wdata_i;
  logic [1:0]                  rq_yumi_o;
  logic [1:0]                  rs_valid_o;
  logic [data_width_p-1:0]     rs_rdata_o;
  logic [1:0]                  rs_yumi_i;
  // memory side
  logic                        m_valid_o;
  logic                        m_wen_o;
  logic                        m_byte_o;
  logic [addr_width_p-1:0]     m_addr_o;
  logic [data_width_p-1:0]     m_wdata_o;
  logic                        m_yumi_i;
  logic                        m_rvalid_i;
  logic [data_width_p-1:0]     m_rdata_i;
  logic                        m_ryumi_o;

  // arbiter view
  modport slave (
    input  rq_valid_i, rq_wen_i, rq_byte_i, rq_addr_i, rq_wdata_i, rs_yumi_i,
    input  m_yumi_i, m_rvalid_i, m_rdata_i,
    output rq_yumi_o, rs_valid_o, rs_rdata_o,
    output m_valid_o, m_wen_o, m_byte_o, m_addr_o, m_wdata_o, m_ryumi_o
  );

  // requesters + memory view
  modport master (
    output rq_valid_i, rq_wen_i, rq_byte_i, rq_addr_i, rq_wdata_i, rs_yumi_i,
    output m_yumi_i, m_rvalid_i, m_rdata_i,
    input  rq_yumi_o, rs_valid_o, rs_rdata_o,
    input  m_valid_o, m_wen_o, m_byte_o, m_addr_o, m_wdata_o, m_ryumi_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Purpose: round-robin share of one data-memory port between core (0) and net loader (1), one transaction in flight.
// Latency: 1 cycle arbitration (IDLE) before the request reaches memory; one IDLE bubble between transactions.
// Backpressure: requester holds its request until rq_yumi_o; memory response held until m_ryumi_o; watchdog aborts stalls.
module dmem_port_arbiter #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int timeout_p    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus,
  output logic                 grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int wd_w_lp = (timeout_p > 2) ? $clog2(timeout_p) : 1;
  localparam logic [wd_w_lp-1:0] wd_max_lp = wd_w_lp'(timeout_p - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic [wd_w_lp-1:0]   wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 req_vld;
  logic                 accept;
  logic                 complete;
  logic                 wd_fire;
  logic [1:0]           rq_yumi;
  logic [1:0]           rs_valid;
  logic                 m_valid;
  logic                 m_ryumi;
  logic [data_width_p-1:0] rs_rdata;

  // Per-cycle handshake qualifiers; these depend only on inputs and state so the watchdog can see a same-cycle completion.
  always_comb begin
    req_vld  = bus.rq_valid_i[grant_q];
    accept   = (state_q == REQ) && req_vld && bus.m_yumi_i;
    complete = 1'b0;
    if (state_q == REQ) begin
      complete = accept && bus.m_rvalid_i && bus.rs_yumi_i[grant_q];
    end else if (state_q == RESP) begin
      complete = bus.m_rvalid_i && bus.rs_yumi_i[grant_q];
    end
    wd_fire = (state_q != IDLE) && (wd_cnt_q == wd_max_lp) && !complete;
  end

  // Next-state, grant, watchdog and handshake outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = timeout_q | wd_fire;
    wd_cnt_d  = (state_q == IDLE) ? '0 : wd_cnt_q + 1'b1;
    rq_yumi   = 2'b00;
    rs_valid  = 2'b00;
    m_valid   = 1'b0;
    m_ryumi   = 1'b0;
    rs_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.rq_valid_i == 2'b11) begin
          grant_d = ~grant_q;
          state_d = REQ;
        end else if (bus.rq_valid_i != 2'b00) begin
          grant_d = bus.rq_valid_i[1];
          state_d = REQ;
        end
      end
      REQ: begin
        m_valid  = req_vld;
        rs_rdata = bus.m_rdata_i;
        if (wd_fire) begin
          state_d = IDLE;
        end else if (accept) begin
          rq_yumi[grant_q]  = 1'b1;
          rs_valid[grant_q] = bus.m_rvalid_i;
          m_ryumi           = complete;
          state_d           = complete ? IDLE : RESP;
        end else if (!req_vld) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        rs_rdata = bus.m_rdata_i;
        if (wd_fire) begin
          state_d = IDLE;
        end else begin
          rs_valid[grant_q] = bus.m_rvalid_i;
          m_ryumi           = complete;
          if (complete) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is a straight mux from the granted requester, presented only while requesting.
  always_comb begin
    bus.m_wen_o   = 1'b0;
    bus.m_byte_o  = 1'b0;
    bus.m_addr_o  = '0;
    bus.m_wdata_o = '0;
    if (state_q == REQ) begin
      bus.m_wen_o   = bus.rq_wen_i[grant_q];
      bus.m_byte_o  = bus.rq_byte_i[grant_q];
      bus.m_addr_o  = grant_q ? bus.rq_addr_i[addr_width_p +: addr_width_p]
                              : bus.rq_addr_i[0 +: addr_width_p];
      bus.m_wdata_o = grant_q ? bus.rq_wdata_i[data_width_p +: data_width_p]
                              : bus.rq_wdata_i[0 +: data_width_p];
    end
  end

  assign bus.rq_yumi_o  = rq_yumi;
  assign bus.rs_valid_o = rs_valid;
  assign bus.rs_rdata_o = rs_rdata;
  assign bus.m_valid_o  = m_valid;
  assign bus.m_ryumi_o  = m_ryumi;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != IDLE);
  assign timeout_o      = timeout_q;

  // State registers; grant resets to 1 so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose: directed self-checking bench for dmem_port_arbiter (load, contention, same-cycle, watchdog, reset, withdraw).
// Latency: checks taken 1-2 ns after the rising edge, inputs driven just after the edge.
// Backpressure: bench plays both requesters and the memory.
module tb_dmem_port_arbiter;

  localparam int aw_lp = 32;
  localparam int dw_lp = 32;

  logic clk;
  logic reset;
  logic grant_o;
  logic busy_o;
  logic timeout_o;

  int n_chk;
  int n_fail;

  dmem_port_arbiter_if #(.addr_width_p(aw_lp), .data_width_p(dw_lp)) bus ();

  dmem_port_arbiter #(
    .addr_width_p(aw_lp),
    .data_width_p(dw_lp),
    .timeout_p   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_o  (grant_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rq_valid_i = 2'b00;
    bus.rq_wen_i   = 2'b00;
    bus.rq_byte_i  = 2'b00;
    bus.rq_addr_i  = '0;
    bus.rq_wdata_i = '0;
    bus.rs_yumi_i  = 2'b00;
    bus.m_yumi_i   = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    reset  = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_busy",    64'(busy_o), 64'h0);
    chk("rst_grant",   64'(grant_o), 64'h1);
    chk("rst_timeout", 64'(timeout_o), 64'h0);
    chk("rst_rq_yumi", 64'(bus.rq_yumi_o), 64'h0);
    chk("rst_rs_vld",  64'(bus.rs_valid_o), 64'h0);
    chk("rst_m_vld",   64'(bus.m_valid_o), 64'h0);
    chk("rst_m_ryumi", 64'(bus.m_ryumi_o), 64'h0);

    // core-only load, cycle 0 = request raised in IDLE
    bus.rq_valid_i = 2'b01;
    bus.rq_addr_i  = {32'h0, 32'h0000_0040};
    #1;
    chk("ld_c0_m_vld", 64'(bus.m_valid_o), 64'h0);
    chk("ld_c0_busy",  64'(busy_o), 64'h0);
    tick();
    chk("ld_c1_busy",  64'(busy_o), 64'h1);
    chk("ld_c1_m_vld", 64'(bus.m_valid_o), 64'h1);
    chk("ld_c1_addr",  64'(bus.m_addr_o), 64'h40);
    chk("ld_c1_wen",   64'(bus.m_wen_o), 64'h0);
    chk("ld_c1_yumi",  64'(bus.rq_yumi_o), 64'h0);
    chk("ld_c1_grant", 64'(grant_o), 64'h0);
    tick();
    bus.m_yumi_i = 1'b1;
    #1;
    chk("ld_c2_yumi",  64'(bus.rq_yumi_o), 64'h1);
    tick();
    bus.m_yumi_i   = 1'b0;
    bus.rq_valid_i = 2'b00;
    #1;
    chk("ld_c3_m_vld", 64'(bus.m_valid_o), 64'h0);
    chk("ld_c3_rs_vld", 64'(bus.rs_valid_o), 64'h0);
    chk("ld_c3_busy",  64'(busy_o), 64'h1);
    tick();
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 32'hDEAD_BEEF;
    bus.rs_yumi_i  = 2'b01;
    #1;
    chk("ld_c4_rs_vld", 64'(bus.rs_valid_o), 64'h1);
    chk("ld_c4_rdata", 64'(bus.rs_rdata_o), 64'hDEAD_BEEF);
    chk("ld_c4_ryumi", 64'(bus.m_ryumi_o), 64'h1);
    tick();
    clear_inputs();
    #1;
    chk("ld_c5_busy",  64'(busy_o), 64'h0);
    // unsolicited response while idle is ignored
    bus.m_rvalid_i = 1'b1;
    #1;
    chk("idle_rv_ryumi", 64'(bus.m_ryumi_o), 64'h0);
    chk("idle_rv_rsvld", 64'(bus.rs_valid_o), 64'h0);
    bus.m_rvalid_i = 1'b0;

    // contention from a fresh reset: grants alternate 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.rq_valid_i = 2'b11;
    bus.rq_addr_i  = {32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_idle_m_vld", 64'(bus.m_valid_o), 64'h0);
      chk("ct_idle_yumi",  64'(bus.rq_yumi_o), 64'h0);
      tick();
      bus.m_yumi_i = 1'b1;
      #1;
      chk("ct_grant", 64'(grant_o), 64'(i % 2));
      chk("ct_yumi",  64'(bus.rq_yumi_o), (i % 2 == 1) ? 64'h2 : 64'h1);
      chk("ct_addr",  64'(bus.m_addr_o), (i % 2 == 1) ? 64'h200 : 64'h100);
      tick();
      bus.m_yumi_i   = 1'b0;
      bus.m_rvalid_i = 1'b1;
      bus.m_rdata_i  = 32'(i);
      bus.rs_yumi_i  = 2'b11;
      #1;
      chk("ct_rs_vld", 64'(bus.rs_valid_o), (i % 2 == 1) ? 64'h2 : 64'h1);
      chk("ct_rq_yumi_resp", 64'(bus.rq_yumi_o), 64'h0);
      tick();
      bus.m_rvalid_i = 1'b0;
      bus.rs_yumi_i  = 2'b00;
      #1;
      chk("ct_bubble", 64'(busy_o), 64'h0);
    end
    clear_inputs();

    // same-cycle accept + response on a core store (grant_r is now 1, core is alone)
    tick();
    bus.rq_valid_i = 2'b01;
    bus.rq_wen_i   = 2'b01;
    bus.rq_wdata_i = {32'h0, 32'h1234_5678};
    tick();
    bus.m_yumi_i   = 1'b1;
    bus.m_rvalid_i = 1'b1;
    bus.rs_yumi_i  = 2'b01;
    #1;
    chk("sc_yumi",   64'(bus.rq_yumi_o), 64'h1);
    chk("sc_rs_vld", 64'(bus.rs_valid_o), 64'h1);
    chk("sc_ryumi",  64'(bus.m_ryumi_o), 64'h1);
    chk("sc_wen",    64'(bus.m_wen_o), 64'h1);
    chk("sc_wdata",  64'(bus.m_wdata_o), 64'h1234_5678);
    tick();
    clear_inputs();
    #1;
    chk("sc_idle", 64'(busy_o), 64'h0);

    // watchdog: net request, memory never accepts; enters REQ at cycle 1, flag at cycle 9
    bus.rq_valid_i = 2'b10;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wd_busy",    64'(busy_o), 64'h1);
      chk("wd_pending", 64'(timeout_o), 64'h0);
      tick();
    end
    bus.rq_valid_i = 2'b00;
    #1;
    chk("wd_flag", 64'(timeout_o), 64'h1);
    chk("wd_idle", 64'(busy_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_sticky", 64'(timeout_o), 64'h1);
    end

    // reset while a response is pending in RESP
    bus.rq_valid_i = 2'b01;
    tick();
    bus.m_yumi_i = 1'b1;
    tick();
    bus.m_yumi_i   = 1'b0;
    bus.rq_valid_i = 2'b00;
    bus.m_rvalid_i = 1'b1;
    #1;
    chk("rr_rs_vld",  64'(bus.rs_valid_o), 64'h1);
    chk("rr_ryumi",   64'(bus.m_ryumi_o), 64'h0);
    chk("rr_grant",   64'(grant_o), 64'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rr_busy",    64'(busy_o), 64'h0);
    chk("rr_ryumi0",  64'(bus.m_ryumi_o), 64'h0);
    chk("rr_rs_vld0", 64'(bus.rs_valid_o), 64'h0);
    chk("rr_timeout", 64'(timeout_o), 64'h0);
    chk("rr_grant1",  64'(grant_o), 64'h1);
    bus.m_rvalid_i = 1'b0;

    // withdraw: net drops valid in REQ before memory accepts
    bus.rq_valid_i = 2'b10;
    tick();
    chk("wdr_m_vld", 64'(bus.m_valid_o), 64'h1);
    bus.rq_valid_i = 2'b00;
    bus.m_yumi_i   = 1'b0;
    #1;
    chk("wdr_m_vld0", 64'(bus.m_valid_o), 64'h0);
    chk("wdr_yumi",   64'(bus.rq_yumi_o), 64'h0);
    tick();
    chk("wdr_idle",   64'(busy_o), 64'h0);
    // a fresh stalled request must get the full watchdog window (counter was cleared)
    bus.rq_valid_i = 2'b01;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wdr_window", 64'(busy_o), 64'h1);
      tick();
    end
    bus.rq_valid_i = 2'b00;
    #1;
    chk("wdr_to_flag", 64'(timeout_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
